word_packer: RTL and testbench
==============================

WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 SHALL have parameter WORD_W, default 6: width of each incoming shift-register word.
REQ-002 SHALL have parameter PACK, default 4: number of input words per output word. Legal range 2..7.
REQ-003 SHALL have a single clock domain and a reset port: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: in_data is valid this cycle.
REQ-007 SHALL have port in_data, input, WORD_W: the upstream shift-register dataOut word.
REQ-008 SHALL have port in_ready, output, 1: the packer accepts in_data this cycle.
REQ-009 SHALL have port flush, input, 1: emit any partial accumulation.
REQ-010 SHALL have port out_valid, output, 1: out_data and out_count are valid.
REQ-011 SHALL have port out_data, output, WORD_W*PACK: the packed word.
REQ-012 SHALL have port out_count, output, 3: number of valid input words in out_data (1..PACK).
REQ-013 SHALL have port out_ready, input, 1: the consumer takes the output this cycle.

Function
REQ-014 SHALL treat an input as accepted when in_valid and in_ready are both high on a rising clk edge. A transfer is likewise out_valid and out_ready.
REQ-015 SHALL hold an accumulator and a fill counter (0..PACK-1). The first accepted word goes to bits [WORD_W-1:0], and each following word goes to the next higher slot.
REQ-016 SHALL push {in_data, accumulator} with count=PACK into a 2-entry output FIFO when the PACK-th word is accepted, and SHALL clear the fill counter to 0.
REQ-017 SHALL assert out_valid on the cycle after the push, a latency of 1 cycle from the final accept.
REQ-018 SHALL drive in_ready = (FIFO occupancy < 2) from registered state only, with no combinational path from out_ready.
REQ-019 SHALL keep out_data and out_count stable while out_valid=1 and out_ready=0.
REQ-020 SHALL push the accumulator zero-padded, with count=fill, when flush=1 and fill>0 and the FIFO is not full.
REQ-021 SHALL include a word accepted in the same cycle as flush before the flush is applied. If that word completes PACK, only the full word is pushed.
REQ-022 SHALL ignore flush when fill=0 and no word is accepted. When the FIFO is full, flush SHALL be held pending until space frees.
REQ-023 SHALL support a simultaneous push and pop at occupancy 1 with the occupancy unchanged. At occupancy 2 the pop SHALL free a slot and in_ready SHALL rise the next cycle.
REQ-024 SHALL emit words in acceptance order, never drop a word and never duplicate a word.

Reset
REQ-025 SHALL, while reset=0: out_valid=0, out_data=0, out_count=0, in_ready=0, fill=0, FIFO empty.
REQ-026 SHALL set in_ready=1 on the first clk edge after reset rises.
REQ-027 SHALL, on reset mid-operation, discard the partial accumulation and all FIFO contents.

Configuration
REQ-028 SHALL, with WORD_PACKER_PARITY_EN defined, add output out_parity (1 bit) = XOR of all out_data bits, registered with its FIFO entry.
REQ-029 SHALL, without WORD_PACKER_PARITY_EN, have no out_parity port and no parity logic.

Structure
REQ-030 SHALL place WORD_W, PACK, OUT_W=WORD_W*PACK and the count width constant in package word_packer_pkg.
REQ-031 SHALL implement the 2-entry output FIFO as sub-module packer_fifo2, with data, count and optional parity fields.

Verification
REQ-032 SHALL check: accept 1,2,3,4 with out_ready=1 -> one cycle later out_valid=1, out_data=0x103081, out_count=4.
REQ-033 SHALL check: out_ready=0, offer 12 words continuously -> in_ready falls after the 8th accept, out_data is stable, and the 9th word is accepted only after the first pop.
REQ-034 SHALL check: accept 0x3F, 0x01, then flush=1 -> out_data=0x00007F, out_count=2, and the next full word starts at bit 0.
REQ-035 SHALL check: accept 2 words, pulse reset low -> all outputs 0; after release, 4 new words give count=4 with no stale bits.
REQ-036 SHALL check: flush in the same cycle as the 4th word -> exactly one push, count=4, and no empty partial word.
REQ-037 SHALL check, with WORD_PACKER_PARITY_EN: words 1,2,3,4 -> out_parity=1.

Source files
------------

// File: rtl/word_packer_pkg.sv
// Shared constants for the word packer: default geometry and the output count width.
// Optional out_parity field is enabled by WORD_PACKER_PARITY_EN.
package word_packer_pkg;
   localparam int WORD_W = 6;
   localparam int PACK   = 4;
   localparam int OUT_W  = WORD_W * PACK;
   // Wide enough for the full count range 1..7.
   localparam int CNT_W  = 3;
endpackage

// File: rtl/word_packer_if.sv
// Handshake bundle between producer, packer and consumer.
// out_parity exists only when WORD_PACKER_PARITY_EN is defined.
interface word_packer_if #(
   parameter int WORD_W = word_packer_pkg::WORD_W,
   parameter int PACK   = word_packer_pkg::PACK
);
   import word_packer_pkg::CNT_W;

   logic                   in_valid;
   logic [WORD_W-1:0]      in_data;
   logic                   in_ready;
   logic                   flush;
   logic                   out_valid;
   logic [WORD_W*PACK-1:0] out_data;
   logic [CNT_W-1:0]       out_count;
   logic                   out_ready;
`ifdef WORD_PACKER_PARITY_EN
   logic                   out_parity;

   modport master (output in_valid, in_data, flush, out_ready,
                   input  in_ready, out_valid, out_data, out_count, out_parity);
   modport slave  (input  in_valid, in_data, flush, out_ready,
                   output in_ready, out_valid, out_data, out_count, out_parity);
`else
   modport master (output in_valid, in_data, flush, out_ready,
                   input  in_ready, out_valid, out_data, out_count);
   modport slave  (input  in_valid, in_data, flush, out_ready,
                   output in_ready, out_valid, out_data, out_count);
`endif
endinterface

// File: rtl/word_packer_fifo2.sv
// Two-entry output FIFO holding packed data, word count and (with
// WORD_PACKER_PARITY_EN) a parity bit; rdy is a registered "not full".
module packer_fifo2
   import word_packer_pkg::*;
#(
   parameter int DW = OUT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [DW-1:0]    push_data,
   input  logic [CNT_W-1:0] push_cnt,
`ifdef WORD_PACKER_PARITY_EN
   input  logic             push_par,
`endif
   input  logic             pop,
   output logic             vld,
   output logic [DW-1:0]    data,
   output logic [CNT_W-1:0] cnt,
`ifdef WORD_PACKER_PARITY_EN
   output logic             par,
`endif
   output logic             full,
   output logic             rdy
);
   logic [1:0][DW-1:0]    mem_d;
   logic [1:0][CNT_W-1:0] mem_c;
`ifdef WORD_PACKER_PARITY_EN
   logic [1:0]            mem_p;
`endif
   logic                  wp, rp;
   logic [1:0]            occ, occ_nxt;
   logic                  do_push, do_pop;

   assign full    = (occ == 2'd2);
   assign vld     = (occ != 2'd0);
   assign do_push = push & ~full;
   assign do_pop  = pop & vld;
   assign occ_nxt = occ + {1'b0, do_push} - {1'b0, do_pop};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_d <= '0;
         mem_c <= '0;
`ifdef WORD_PACKER_PARITY_EN
         mem_p <= '0;
`endif
         wp    <= 1'b0;
         rp    <= 1'b0;
         occ   <= 2'd0;
         rdy   <= 1'b0;
      end else begin
         if (do_push) begin
            mem_d[wp] <= push_data;
            mem_c[wp] <= push_cnt;
`ifdef WORD_PACKER_PARITY_EN
            mem_p[wp] <= push_par;
`endif
            wp        <= ~wp;
         end
         if (do_pop) rp <= ~rp;
         occ <= occ_nxt;
         // Registered so in_ready never depends combinationally on out_ready.
         rdy <= (occ_nxt != 2'd2);
      end
   end

   assign data = mem_d[rp];
   assign cnt  = mem_c[rp];
`ifdef WORD_PACKER_PARITY_EN
   assign par  = mem_p[rp];
`endif
endmodule

// File: rtl/word_packer.sv
// Packs PACK narrow words into one wide word, with flush of partial words.
// WORD_PACKER_PARITY_EN adds a registered out_parity per output entry.
module word_packer #(
   parameter int WORD_W = word_packer_pkg::WORD_W,
   parameter int PACK   = word_packer_pkg::PACK
) (
   input  logic         clk,
   input  logic         reset,
   word_packer_if.slave bus
);
   import word_packer_pkg::CNT_W;

   localparam int DW = WORD_W * PACK;

   logic [CNT_W-1:0] fill, fill_a, fill_nxt;
   logic [DW-1:0]    acc, acc_a, acc_nxt, in_shf;
   logic             pend, pend_nxt;
   logic             accept, flush_req, full, push, pop;

   assign accept    = bus.in_valid & bus.in_ready;
   assign flush_req = bus.flush | pend;
   assign pop       = bus.out_valid & bus.out_ready;
   assign in_shf    = DW'(bus.in_data) << (WORD_W * int'(fill));

   // A word accepted this cycle is folded in before any flush decision.
   always_comb begin
      fill_a   = fill + CNT_W'(accept);
      acc_a    = accept ? (acc | in_shf) : acc;
      push     = 1'b0;
      fill_nxt = fill_a;
      acc_nxt  = acc_a;
      pend_nxt = pend;
      if (fill_a == CNT_W'(PACK)) begin
         push     = 1'b1;
         fill_nxt = '0;
         acc_nxt  = '0;
         pend_nxt = 1'b0;
      end else if (flush_req) begin
         if (fill_a == '0) begin
            pend_nxt = 1'b0;
         end else if (!full) begin
            push     = 1'b1;
            fill_nxt = '0;
            acc_nxt  = '0;
            pend_nxt = 1'b0;
         end else begin
            pend_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fill <= '0;
         acc  <= '0;
         pend <= 1'b0;
      end else begin
         fill <= fill_nxt;
         acc  <= acc_nxt;
         pend <= pend_nxt;
      end
   end

   packer_fifo2 #(.DW(DW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (acc_a),
      .push_cnt  (fill_a),
`ifdef WORD_PACKER_PARITY_EN
      .push_par  (^acc_a),
`endif
      .pop       (pop),
      .vld       (bus.out_valid),
      .data      (bus.out_data),
      .cnt       (bus.out_count),
`ifdef WORD_PACKER_PARITY_EN
      .par       (bus.out_parity),
`endif
      .full      (full),
      .rdy       (bus.in_ready)
   );
endmodule

// File: tb/tb_word_packer.sv
// Scoreboard bench for word_packer: directed scenarios plus random traffic
// checked against a word-queue reference model.
module tb_word_packer;
   import word_packer_pkg::*;

   typedef struct {
      logic [63:0] d;
      int          c;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   word_packer_if bus ();
   word_packer dut (.clk(clk), .reset(reset), .bus(bus));

   int          checks = 0, failures = 0;
   exp_t        expq[$];
   logic [7:0]  part[$];
   bit          pend = 0, armed = 0;
   int          occ = 0;
   logic [63:0] last_d = 0;
   int          last_c = 0, npops = 0;
   bit          hold = 0;
   logic [63:0] hold_d;
   int          hold_c;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] packw(input logic [7:0] q[$]);
      logic [63:0] v = 0;
      for (int i = 0; i < q.size(); i++) v += 64'(q[i]) << (i * WORD_W);
      return v;
   endfunction

   // Reference model: words collect in a queue; full or flushed groups become expected outputs.
   always @(negedge clk) begin
      bit   pop_b, acc_b, push_b;
      exp_t e;
      if (!reset) begin
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_out_data", bus.out_data, 0);
         chk("rst_out_count", bus.out_count, 0);
         chk("rst_in_ready", bus.in_ready, 0);
         part.delete();
         expq.delete();
         pend  = 0;
         occ   = 0;
         armed = 0;
      end else if (!armed) begin
         chk("pre_edge_in_ready", bus.in_ready, 0);
         armed = 1;
      end else begin
         chk("in_ready", bus.in_ready, occ < 2);
         chk("out_valid", bus.out_valid, occ > 0);
         pop_b  = bus.out_valid && bus.out_ready;
         acc_b  = bus.in_valid && bus.in_ready;
         push_b = 0;
         if (acc_b) part.push_back(8'(bus.in_data));
         if (part.size() == PACK) begin
            e.d = packw(part); e.c = PACK; push_b = 1;
            part.delete(); pend = 0;
         end else if (bus.flush || pend) begin
            if (part.size() == 0) pend = 0;
            else if (occ < 2) begin
               e.d = packw(part); e.c = part.size(); push_b = 1;
               part.delete(); pend = 0;
            end else pend = 1;
         end
         if (push_b) expq.push_back(e);
         occ = occ + int'(push_b) - int'(pop_b);
      end
   end

   // Monitor: compares every output transfer with the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) hold = 0;
      else begin
         if (hold) begin
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_data", bus.out_data, hold_d);
            chk("stall_count", bus.out_count, hold_c);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_output: got 0x%0h expected none", bus.out_data);
            end else begin
               e = expq.pop_front();
               chk("out_data", bus.out_data, e.d);
               chk("out_count", bus.out_count, e.c);
`ifdef WORD_PACKER_PARITY_EN
               chk("out_parity", bus.out_parity, ^e.d);
`endif
            end
            last_d = 64'(bus.out_data);
            last_c = int'(bus.out_count);
            npops++;
         end
         hold   = bus.out_valid && !bus.out_ready;
         hold_d = 64'(bus.out_data);
         hold_c = int'(bus.out_count);
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [WORD_W-1:0] w, input logic fl);
      bit ok = 0;
      int n  = 0;
      bus.in_valid = 1; bus.in_data = w; bus.flush = fl;
      do begin
         @(negedge clk); ok = bus.in_ready; cyc(); n++;
      end while (!ok && n < 64);
      if (!ok) begin
         checks++; failures++;
         $display("FAIL send_timeout: got no accept expected accept within 64 cycles");
      end
      bus.in_valid = 0; bus.flush = 0;
   endtask

   initial begin
      #4000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int np;
      bus.in_valid = 0; bus.in_data = '0; bus.flush = 0; bus.out_ready = 1;
      #1 reset = 0;
      repeat (3) cyc();
      reset = 1;
      cyc();

      // Basic pack 1,2,3,4 and one-cycle latency.
      for (int i = 1; i <= 4; i++) send(WORD_W'(i), 0);
      @(negedge clk); chk("t1_latency_valid", bus.out_valid, 1);
      cyc(); repeat (3) cyc();
      chk("t1_data", last_d, 64'h103081);
      chk("t1_count", last_c, 4);

      // Backpressure: eight accepts fill the FIFO, ninth waits for a pop.
      bus.out_ready = 0; np = npops;
      for (int i = 0; i < 8; i++) send(WORD_W'($urandom_range(0, 63)), 0);
      @(negedge clk); chk("t2_in_ready_low", bus.in_ready, 0);
      cyc();
      chk("t2_no_pop", npops - np, 0);
      fork
         send(WORD_W'($urandom_range(0, 63)), 0);
         begin repeat (3) cyc(); bus.out_ready = 1; end
      join
      for (int i = 0; i < 3; i++) send(WORD_W'($urandom_range(0, 63)), 0);
      repeat (8) cyc();
      chk("t2_pops", npops - np, 3);

      // Partial flush, then a fresh word starts at bit 0.
      send(6'h3F, 0); send(6'h01, 0);
      bus.flush = 1; cyc(); bus.flush = 0;
      repeat (3) cyc();
      chk("t3_flush_data", last_d, 64'h7F);
      chk("t3_flush_count", last_c, 2);
      for (int i = 5; i <= 8; i++) send(WORD_W'(i), 0);
      repeat (3) cyc();
      chk("t3_next_data", last_d, 64'h207185);

      // Reset mid-accumulation discards the partial word.
      send(6'h2A, 0); send(6'h15, 0);
      reset = 0; cyc(); cyc(); reset = 1; cyc();
      for (int i = 9; i <= 12; i++) send(WORD_W'(i), 0);
      repeat (3) cyc();
      chk("t4_data", last_d, 64'h30B289);
      chk("t4_count", last_c, 4);

      // Flush together with the completing word: a single full push.
      np = npops;
      for (int i = 1; i <= 3; i++) send(WORD_W'(i), 0);
      send(6'd4, 1);
      repeat (5) cyc();
      chk("t5_one_push", npops - np, 1);
      chk("t5_count", last_c, 4);
      chk("t5_data", last_d, 64'h103081);

      // Random traffic with occasional mid-run reset.
      for (int i = 0; i < 1500; i++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.in_data   = WORD_W'($urandom_range(0, 63));
         bus.flush     = ($urandom_range(0, 7) == 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 399) == 0) begin
            reset = 0; cyc(); cyc(); reset = 1;
         end
         cyc();
      end

      bus.in_valid = 0; bus.out_ready = 1; bus.flush = 1;
      cyc();
      bus.flush = 0;
      repeat (10) cyc();
      chk("drain_empty", expq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
